ceespu_gshare_predictor: RTL and testbench
==========================================

CEESPU_GSHARE_PREDICTOR -- requirements
Module: ceespu_gshare_predictor

Interface
REQ-001 SHALL have parameter PHT_BITS, default 6, log2 of pattern history table (PHT) entries.
REQ-002 SHALL have parameter HIST_BITS, default 6, global history length; legal range 1..PHT_BITS.
REQ-003 SHALL have parameter CTR_BITS, default 2, saturating counter width; legal range 2..4.
REQ-004 SHALL have parameter PC_BITS, default 25, instruction address width.
REQ-005 SHALL have parameter BTB_BITS, default 4, log2 of BTB entries; used only when CEESPU_BP_BTB_EN is defined.
REQ-006 SHALL have ports:
 clk  in  1  clock, all state on rising edge
 rst_n  in  1  asynchronous active-low reset
 ready  out  1  high when table initialised and lookups/updates are accepted
 lookup_valid  in  1  lookup request
 lookup_pc  in  PC_BITS  address of branch instruction
 pred_valid  out  1  prediction valid, one cycle after accepted lookup
 pred_taken  out  1  predicted direction (counter MSB)
 pred_state  out  CTR_BITS  counter value read
 pred_index  out  PHT_BITS  PHT index used, carried down pipeline
 pred_hist  out  HIST_BITS  history checkpoint before this lookup's shift
 pred_target  out  PC_BITS  predicted target
 btb_hit  out  1  target valid
 update_valid  in  1  resolved-branch update
 update_index  in  PHT_BITS  index returned from pred_index
 update_state  in  CTR_BITS  state returned from pred_state
 update_hist  in  HIST_BITS  checkpoint returned from pred_hist
 update_taken  in  1  resolved direction
 update_mispredict  in  1  direction or target mispredicted
 update_pc  in  PC_BITS  branch address
 update_target  in  PC_BITS  resolved target

Function
REQ-007 SHALL compute index = lookup_pc[PHT_BITS+1:2] XOR zero-extended global history register (GHR).
REQ-008 SHALL register outputs: lookup accepted at cycle N gives pred_valid=1 at N+1 only; pred_valid=0 otherwise.
REQ-009 SHALL accept a lookup only when ready=1 and lookup_valid=1.
REQ-010 SHALL speculatively shift GHR on accepted lookup: GHR <= {GHR[HIST_BITS-2:0], counter MSB}.
REQ-011 SHALL on accepted update write PHT[update_index] <= update_state+1 if taken, -1 if not, saturating at all-ones and zero.
REQ-012 SHALL on update with update_mispredict=1 repair GHR <= {update_hist[HIST_BITS-2:0], update_taken}.
REQ-013 SHALL give update repair priority over lookup shift in the same cycle; that lookup still issues its prediction using pre-repair GHR.
REQ-014 SHALL return the old PHT value when lookup and update hit the same index in the same cycle (no bypass).
REQ-015 SHALL implement FSM INIT->RUN: INIT writes weakly-taken (2^(CTR_BITS-1)) to entry i, i=0..2^PHT_BITS-1, one per cycle; enters RUN after last entry; ready=1 only in RUN.
REQ-016 SHALL ignore lookup_valid and update_valid in INIT.
REQ-017 SHALL keep GHR at 0 in INIT.

Reset
REQ-018 SHALL on rst_n=0 asynchronously set FSM=INIT, init counter=0, GHR=0, ready=0, pred_valid=0, pred_taken=0, pred_state=0, pred_index=0, pred_hist=0, pred_target=0, btb_hit=0, all BTB valid bits=0.
REQ-019 SHALL restart initialisation from entry 0 when reset is asserted mid-INIT or mid-RUN.

Configuration
REQ-020 SHALL include, when CEESPU_BP_BTB_EN is defined, a direct-mapped BTB of 2^BTB_BITS entries {valid, tag=pc[PC_BITS-1:BTB_BITS+2], target} indexed by pc[BTB_BITS+1:2]; lookup hit gives btb_hit=1, pred_target=target; update with update_taken=1 writes entry, valid=1.
REQ-021 SHALL, when CEESPU_BP_BTB_EN is undefined, contain no BTB storage and drive btb_hit=0, pred_target=0 constantly.

Verification
REQ-022 Reset release, defaults: ready=0 for exactly 64 cycles, then 1; first lookup pc=0x40 -> pred_taken=1, pred_state=2, pred_index=0x10.
REQ-023 Five taken updates index 5 starting state 2 -> states 3,3,3 (saturates); five not-taken from 0 -> stays 0.
REQ-024 Lookups at pcs 0x0,0x4 predicting taken -> GHR 0b11; mispredict update with update_hist=0b000001, taken=0 -> GHR=0b000010.
REQ-025 Same-cycle lookup and mispredict update -> GHR equals repaired value, not shifted; pred_valid=1 next cycle.
REQ-026 BTB_EN: taken update pc=0x100 target=0x2000, then lookup 0x100 -> btb_hit=1, pred_target=0x2000; lookup 0x140 (same set, other tag) -> btb_hit=0; without macro btb_hit=0 always.
REQ-027 rst_n pulse at INIT cycle 30 -> ready stays 0 for 64 further cycles, all entries read weakly-taken.

Source files
------------

// File: rtl/ceespu_gshare_predictor.sv
// ceespu_gshare_predictor
// Gshare branch direction predictor. It has a pattern history table (PHT) of
// saturating counters, indexed by PC bits XOR the global history register (GHR).
// The GHR is updated speculatively on every lookup. When a branch is
// mispredicted, the GHR is repaired from the checkpoint carried with that branch.
// After reset, an init FSM writes every PHT entry to weakly-taken, one entry per
// cycle, before ready goes high.
// Optional feature: define CEESPU_BP_BTB_EN to add a direct-mapped branch
// target buffer. Without it, btb_hit and pred_target are tied to zero.
module ceespu_gshare_predictor #(
    parameter int PHT_BITS  = 6,
    parameter int HIST_BITS = 6,
    parameter int CTR_BITS  = 2,
    parameter int PC_BITS   = 25,
    parameter int BTB_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ready,
    input  logic                 lookup_valid,
    input  logic [PC_BITS-1:0]   lookup_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [CTR_BITS-1:0]  pred_state,
    output logic [PHT_BITS-1:0]  pred_index,
    output logic [HIST_BITS-1:0] pred_hist,
    output logic [PC_BITS-1:0]   pred_target,
    output logic                 btb_hit,
    input  logic                 update_valid,
    input  logic [PHT_BITS-1:0]  update_index,
    input  logic [CTR_BITS-1:0]  update_state,
    input  logic [HIST_BITS-1:0] update_hist,
    input  logic                 update_taken,
    input  logic                 update_mispredict,
    input  logic [PC_BITS-1:0]   update_pc,
    input  logic [PC_BITS-1:0]   update_target
);

    localparam int PHT_ENTRIES = 1 << PHT_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [PHT_BITS-1:0] LAST_ENTRY = {PHT_BITS{1'b1}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state;
    state_t                state_next;
    logic [PHT_BITS-1:0]   init_cnt;
    logic [HIST_BITS-1:0]  ghr;
    logic [CTR_BITS-1:0]   pht [PHT_ENTRIES];
    logic                  lookup_fire;
    logic                  update_fire;
    logic [PHT_BITS-1:0]   lookup_index;
    logic [CTR_BITS-1:0]   lookup_ctr;
    logic [CTR_BITS-1:0]   update_next_state;
    logic                  unused_inputs;

    assign ready        = (state == ST_RUN);
    assign lookup_fire  = ready & lookup_valid;
    assign update_fire  = ready & update_valid;
    assign lookup_index = lookup_pc[PHT_BITS+1:2] ^ PHT_BITS'(ghr);
    assign lookup_ctr   = pht[lookup_index];

    // Some PC bits feed only the optional BTB. They are gathered into one sink
    // so that every build uses every input bit.
    assign unused_inputs = ^{lookup_pc, update_pc, update_target};

    // Saturating increment/decrement of the counter value returned by the pipeline
    always_comb begin
        update_next_state = update_state;
        if (update_taken && (update_state != {CTR_BITS{1'b1}}))
            update_next_state = update_state + CTR_BITS'(1);
        else if (!update_taken && (update_state != {CTR_BITS{1'b0}}))
            update_next_state = update_state - CTR_BITS'(1);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_INIT;
        else
            state <= state_next;
    end

    // FSM next state: move to RUN once the last PHT entry has been written
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_cnt == LAST_ENTRY) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // Init sweep pointer, one PHT entry per cycle while in INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            init_cnt <= '0;
        else if (state == ST_INIT)
            init_cnt <= init_cnt + PHT_BITS'(1);
    end

    // Global history: mispredict repair wins over the speculative lookup shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ghr <= '0;
        else if (state == ST_INIT)
            ghr <= '0;
        else if (update_fire && update_mispredict)
            ghr <= HIST_BITS'({update_hist, update_taken});
        else if (lookup_fire)
            ghr <= HIST_BITS'({ghr, lookup_ctr[CTR_BITS-1]});
    end

    // PHT storage. Not reset; the init sweep overwrites every entry.
    always_ff @(posedge clk) begin
        if (state == ST_INIT)
            pht[init_cnt] <= CTR_WEAK_TAKEN;
        else if (update_fire)
            pht[update_index] <= update_next_state;
    end

    // Registered prediction. A same-cycle update to the same index is not bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_state <= '0;
            pred_index <= '0;
            pred_hist  <= '0;
        end else begin
            pred_valid <= lookup_fire;
            if (lookup_fire) begin
                pred_taken <= lookup_ctr[CTR_BITS-1];
                pred_state <= lookup_ctr;
                pred_index <= lookup_index;
                pred_hist  <= ghr;
            end
        end
    end

`ifdef CEESPU_BP_BTB_EN
    localparam int BTB_ENTRIES = 1 << BTB_BITS;
    localparam int TAG_BITS    = PC_BITS - BTB_BITS - 2;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_BITS-1:0]    btb_tag    [BTB_ENTRIES];
    logic [PC_BITS-1:0]     btb_target [BTB_ENTRIES];
    logic [BTB_BITS-1:0]    lookup_set;
    logic [BTB_BITS-1:0]    update_set;
    logic [TAG_BITS-1:0]    lookup_tag;
    logic [TAG_BITS-1:0]    update_tag;
    logic                   lookup_btb_hit;

    assign lookup_set     = lookup_pc[BTB_BITS+1:2];
    assign update_set     = update_pc[BTB_BITS+1:2];
    assign lookup_tag     = lookup_pc[PC_BITS-1:BTB_BITS+2];
    assign update_tag     = update_pc[PC_BITS-1:BTB_BITS+2];
    assign lookup_btb_hit = btb_valid[lookup_set] && (btb_tag[lookup_set] == lookup_tag);

    // BTB valid bits are reset. Taken branches allocate their entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            btb_valid <= '0;
        else if (update_fire && update_taken)
            btb_valid[update_set] <= 1'b1;
    end

    // BTB tag/target payload, only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (update_fire && update_taken) begin
            btb_tag[update_set]    <= update_tag;
            btb_target[update_set] <= update_target;
        end
    end

    // Registered BTB result, aligned with the direction prediction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_hit     <= 1'b0;
            pred_target <= '0;
        end else if (lookup_fire) begin
            btb_hit     <= lookup_btb_hit;
            pred_target <= lookup_btb_hit ? btb_target[lookup_set] : '0;
        end
    end
`else
    assign btb_hit     = 1'b0;
    assign pred_target = '0;
`endif

endmodule

// File: tb/tb_ceespu_gshare_predictor.sv
// tb_ceespu_gshare_predictor
// Directed bench for the gshare predictor with default parameters.
// It contains a vector table for the lookup/update/GHR behaviour, plus hand
// sequences for counter saturation, the BTB and reset during INIT.
module tb_ceespu_gshare_predictor;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        lookup_valid;
    logic [24:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_state;
    logic [5:0]  pred_index;
    logic [5:0]  pred_hist;
    logic [24:0] pred_target;
    logic        btb_hit;
    logic        update_valid;
    logic [5:0]  update_index;
    logic [1:0]  update_state;
    logic [5:0]  update_hist;
    logic        update_taken;
    logic        update_mispredict;
    logic [24:0] update_pc;
    logic [24:0] update_target;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        lv;
        logic [24:0] lpc;
        logic        uv;
        logic [5:0]  uidx;
        logic [1:0]  ust;
        logic [5:0]  uhist;
        logic        ut;
        logic        um;
        logic        ev;
        logic        et;
        logic [1:0]  es;
        logic [5:0]  ei;
        logic [5:0]  eh;
    } vec_t;

    ceespu_gshare_predictor dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ready             (ready),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .pred_valid        (pred_valid),
        .pred_taken        (pred_taken),
        .pred_state        (pred_state),
        .pred_index        (pred_index),
        .pred_hist         (pred_hist),
        .pred_target       (pred_target),
        .btb_hit           (btb_hit),
        .update_valid      (update_valid),
        .update_index      (update_index),
        .update_state      (update_state),
        .update_hist       (update_hist),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .update_pc         (update_pc),
        .update_target     (update_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit in case the design never becomes ready
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        lookup_valid      = v.lv;
        lookup_pc         = v.lpc;
        update_valid      = v.uv;
        update_index      = v.uidx;
        update_state      = v.ust;
        update_hist       = v.uhist;
        update_taken      = v.ut;
        update_mispredict = v.um;
        update_pc         = '0;
        update_target     = '0;
    endtask

    task automatic clearInputs();
        vec_t z;
        z = '{1'b0, 25'h0, 1'b0, 6'h0, 2'h0, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'h0, 6'h0, 6'h0};
        applyStimulus(z);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady(output int cycles, output int pv_seen);
        cycles  = 0;
        pv_seen = 0;
        while (!ready && cycles < 200) begin
            step();
            cycles++;
            if (pred_valid) pv_seen++;
        end
    endtask

    initial begin
        vec_t      vec [13];
        vec_t      v;
        int        cycles;
        int        pv_seen;
        logic [1:0] s;
        logic [5:0] ghr_m;
        logic [5:0] pc_bits;

        n_checks = 0;
        n_fail   = 0;

        // lv lpc     uv uidx  ust uhist ut um  ev et es ei     eh
        vec[0]  = '{1, 25'h40, 0, 6'h00, 2, 6'h00, 0, 0, 1, 1, 2, 6'h10, 6'h00};
        vec[1]  = '{0, 25'h00, 1, 6'h3F, 2, 6'h00, 0, 1, 0, 0, 0, 6'h00, 6'h00};
        vec[2]  = '{1, 25'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 1, 2, 6'h00, 6'h00};
        vec[3]  = '{1, 25'h04, 0, 6'h00, 0, 6'h00, 0, 0, 1, 1, 2, 6'h00, 6'h01};
        vec[4]  = '{1, 25'h08, 0, 6'h00, 0, 6'h00, 0, 0, 1, 1, 2, 6'h01, 6'h03};
        vec[5]  = '{0, 25'h00, 1, 6'h3E, 2, 6'h01, 0, 1, 0, 0, 0, 6'h00, 6'h00};
        vec[6]  = '{1, 25'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 1, 2, 6'h02, 6'h02};
        vec[7]  = '{1, 25'h0C, 1, 6'h06, 2, 6'h08, 1, 1, 1, 1, 2, 6'h06, 6'h05};
        vec[8]  = '{1, 25'h00, 0, 6'h00, 0, 6'h00, 0, 0, 1, 1, 2, 6'h11, 6'h11};
        vec[9]  = '{1, 25'h94, 0, 6'h00, 0, 6'h00, 0, 0, 1, 1, 3, 6'h06, 6'h23};
        vec[10] = '{1, 25'hE0, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0, 1, 6'h3F, 6'h07};
        vec[11] = '{1, 25'hC0, 0, 6'h00, 0, 6'h00, 0, 0, 1, 0, 1, 6'h3E, 6'h0E};
        vec[12] = '{0, 25'h00, 0, 6'h00, 0, 6'h00, 0, 0, 0, 0, 0, 6'h00, 6'h00};

        $display("[TB] reset and init sweep");
        clearInputs();
        rst_n = 1'b0;
        #3;
        checkOutput("rst_ready",       32'(ready),       32'd0);
        checkOutput("rst_pred_valid",  32'(pred_valid),  32'd0);
        checkOutput("rst_pred_taken",  32'(pred_taken),  32'd0);
        checkOutput("rst_pred_state",  32'(pred_state),  32'd0);
        checkOutput("rst_pred_index",  32'(pred_index),  32'd0);
        checkOutput("rst_pred_hist",   32'(pred_hist),   32'd0);
        checkOutput("rst_btb_hit",     32'(btb_hit),     32'd0);
        checkOutput("rst_pred_target", 32'(pred_target), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitReady(cycles, pv_seen);
        checkOutput("init_cycles", 32'(cycles), 32'd64);

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vec[i]);
            step();
            checkOutput($sformatf("row%0d_valid", i), 32'(pred_valid), 32'(vec[i].ev));
            if (vec[i].ev) begin
                checkOutput($sformatf("row%0d_taken", i), 32'(pred_taken), 32'(vec[i].et));
                checkOutput($sformatf("row%0d_state", i), 32'(pred_state), 32'(vec[i].es));
                checkOutput($sformatf("row%0d_index", i), 32'(pred_index), 32'(vec[i].ei));
                checkOutput($sformatf("row%0d_hist", i),  32'(pred_hist),  32'(vec[i].eh));
`ifndef CEESPU_BP_BTB_EN
                checkOutput($sformatf("row%0d_btb_hit", i), 32'(btb_hit), 32'd0);
`endif
            end
        end

        $display("[TB] counter saturation on entry 5");
        s = 2'd2;
        for (int k = 0; k < 5; k++) begin
            clearInputs();
            v = '{0, 25'h0, 1, 6'h05, s, 6'h00, 1, 1, 0, 0, 0, 6'h0, 6'h0};
            applyStimulus(v);
            step();
            clearInputs();
            lookup_valid = 1'b1;
            lookup_pc    = 25'h10;
            step();
            checkOutput($sformatf("sat_up%0d_index", k), 32'(pred_index), 32'h05);
            checkOutput($sformatf("sat_up%0d_state", k), 32'(pred_state), 32'd3);
            s = pred_state;
        end
        s = 2'd0;
        for (int k = 0; k < 5; k++) begin
            clearInputs();
            v = '{0, 25'h0, 1, 6'h05, s, 6'h00, 0, 1, 0, 0, 0, 6'h0, 6'h0};
            applyStimulus(v);
            step();
            clearInputs();
            lookup_valid = 1'b1;
            lookup_pc    = 25'h14;
            step();
            checkOutput($sformatf("sat_dn%0d_state", k), 32'(pred_state), 32'd0);
            checkOutput($sformatf("sat_dn%0d_taken", k), 32'(pred_taken), 32'd0);
            s = pred_state;
        end
        clearInputs();
        step();

        $display("[TB] BTB allocate and lookup");
        v = '{0, 25'h0, 1, 6'h20, 2, 6'h00, 1, 0, 0, 0, 0, 6'h0, 6'h0};
        applyStimulus(v);
        update_pc     = 25'h100;
        update_target = 25'h2000;
        step();
        clearInputs();
        lookup_valid = 1'b1;
        lookup_pc    = 25'h100;
        step();
`ifdef CEESPU_BP_BTB_EN
        checkOutput("btb_hit_same",    32'(btb_hit),     32'd1);
        checkOutput("btb_target_same", 32'(pred_target), 32'h2000);
`else
        checkOutput("btb_hit_same",    32'(btb_hit),     32'd0);
        checkOutput("btb_target_same", 32'(pred_target), 32'd0);
`endif
        lookup_pc = 25'h140;
        step();
        checkOutput("btb_hit_alias",    32'(btb_hit),     32'd0);
        checkOutput("btb_target_alias", 32'(pred_target), 32'd0);

        $display("[TB] asynchronous reset mid-RUN, then pulse at INIT cycle 30");
        lookup_pc = 25'h0;
        step();
        checkOutput("run_pred_valid", 32'(pred_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_ready",      32'(ready),      32'd0);
        checkOutput("async_pred_valid", 32'(pred_valid), 32'd0);
        checkOutput("async_pred_state", 32'(pred_state), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{1, 25'h20, 1, 6'h05, 3, 6'h3F, 1, 1, 0, 0, 0, 6'h0, 6'h0};
        applyStimulus(v);
        pv_seen = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (pred_valid) pv_seen++;
        end
        checkOutput("init_ignore_lookup", 32'(pv_seen), 32'd0);
        checkOutput("init30_ready",       32'(ready),   32'd0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        waitReady(cycles, pv_seen);
        checkOutput("reinit_cycles",   32'(cycles),  32'd64);
        checkOutput("reinit_no_pred",  32'(pv_seen), 32'd0);
        clearInputs();

        ghr_m = 6'h00;
        for (int i = 0; i < 64; i++) begin
            pc_bits      = 6'(i) ^ ghr_m;
            lookup_valid = 1'b1;
            lookup_pc    = {17'h0, pc_bits, 2'b00};
            step();
            checkOutput($sformatf("sweep%0d_index", i), 32'(pred_index), 32'(i));
            checkOutput($sformatf("sweep%0d_state", i), 32'(pred_state), 32'd2);
            if (i == 0)
                checkOutput("sweep0_hist", 32'(pred_hist), 32'd0);
            ghr_m = {ghr_m[4:0], 1'b1};
        end
        clearInputs();
        step();
        checkOutput("idle_pred_valid", 32'(pred_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
